sipo_rx: RTL and testbench

//  16-bit serial-in/parallel-out receiver; the deserializing end of the piso_2 serial link.

---
 rtl/sipo_rx_if.sv | 27 ++
 rtl/sipo_rx.sv | 100 ++++++++++
 tb/tb_sipo_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// Bundle for the sipo_rx serial input, parallel valid/ready output and status.
// The DUT takes the slave modport; the driving side takes master.
interface sipo_rx_if #(
    parameter int unsigned WIDTH = 16
) ();
    localparam int unsigned CntW = $clog2(WIDTH);

    logic             clr;
    logic             sin_valid;
    logic             sin;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic [CntW-1:0]  bit_cnt;
    logic             overrun;

    modport master (
        output clr, sin_valid, sin, pout_ready,
        input  pout, pout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  clr, sin_valid, sin, pout_ready,
        output pout, pout_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_rx.sv
// MSB-first serial-in/parallel-out receiver with a valid/ready holding register
// and a sticky overrun flag for words lost to backpressure.
module sipo_rx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    sipo_rx_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word;
    logic             last_bit;
    logic             complete;
    logic             accept;

    assign word     = {sreg_q[WIDTH-2:0], bus.sin};
    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);
    assign complete = bus.sin_valid && last_bit;
    assign accept   = pout_valid_q && bus.pout_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            cnt_q        <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.sin_valid) state_d = StShift;
            StShift: if (complete)      state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.clr) state_d = StIdle;
    end

    always_comb begin
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = overrun_q;

        if (bus.sin_valid) begin
            sreg_d = word;
            cnt_d  = last_bit ? '0 : cnt_q + 1'b1;
        end

        // A completing word may replace the held one only if it leaves this edge.
        if (complete) begin
            if (!pout_valid_q || accept) begin
                pout_d       = word;
                pout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            pout_valid_d = 1'b0;
        end

        if (bus.clr) begin
            sreg_d       = '0;
            cnt_d        = '0;
            pout_d       = '0;
            pout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_comb begin
        bus.pout       = pout_q;
        bus.pout_valid = pout_valid_q;
        bus.busy       = (state_q == StShift);
        bus.bit_cnt    = cnt_q;
        bus.overrun    = overrun_q;
    end
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: reset, streaming, gaps, overrun, simultaneous
// completion/accept, and mid-word clear/reset.
module tb_sipo_rx;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sipo_rx_if #(.WIDTH(16)) bus ();

    sipo_rx #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: shift left, serial out is the MSB.
    task automatic send_word(input logic [15:0] w, input bit ready_on_last);
        logic [15:0] sh;
        sh = w;
        for (int i = 0; i < 16; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin       = sh[15];
            sh            = {sh[14:0], 1'b0};
            if (i == 15 && ready_on_last) bus.pout_ready = 1'b1;
            tick();
        end
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.clr       = 1'b0;
        bus.sin_valid = 1'b1;
        bus.sin       = 1'b1;
        bus.pout_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.pout !== 16'h0000) begin
            errors++; $display("FAIL reset_pout got %h want 0000", bus.pout);
        end
        checks++;
        if (bus.pout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%b busy=%b ovr=%b want 0 0 0",
                     bus.pout_valid, bus.busy, bus.overrun);
        end
        checks++;
        if (bus.bit_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_bit_cnt got %0d want 0", bus.bit_cnt);
        end
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
        rst_n         = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] sh;
        bus.pout_ready = 1'b1;
        sh = 16'hA5C3;
        for (int i = 0; i < 15; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin       = sh[15];
            sh            = {sh[14:0], 1'b0};
            tick();
        end
        checks++;
        if (bus.bit_cnt !== 4'd15 || bus.busy !== 1'b1 || bus.pout_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_15bits got cnt=%0d busy=%b valid=%b want 15 1 0",
                     bus.bit_cnt, bus.busy, bus.pout_valid);
        end
        bus.sin = sh[15];
        tick();
        bus.sin_valid = 1'b0;
        checks++;
        if (bus.pout !== 16'hA5C3 || bus.pout_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_word got %h valid=%b want a5c3 valid=1", bus.pout, bus.pout_valid);
        end
        checks++;
        if (bus.bit_cnt !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_wrap got cnt=%0d busy=%b want 0 0", bus.bit_cnt, bus.busy);
        end
        tick();
        checks++;
        if (bus.pout_valid !== 1'b0 || bus.pout !== 16'hA5C3) begin
            errors++;
            $display("FAIL basic_accept got %h valid=%b want a5c3 valid=0", bus.pout, bus.pout_valid);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] sh;
        int          exp_cnt;
        bit          cnt_ok;
        sh      = 16'h8001;
        exp_cnt = 0;
        cnt_ok  = 1'b1;
        bus.pout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin       = sh[15];
            sh            = {sh[14:0], 1'b0};
            tick();
            exp_cnt = (exp_cnt + 1) % 16;
            if (bus.bit_cnt !== 4'(exp_cnt)) cnt_ok = 1'b0;
            if (i == 15) begin
                checks++;
                if (bus.pout !== 16'h8001 || bus.pout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_word got %h valid=%b want 8001 valid=1",
                             bus.pout, bus.pout_valid);
                end
            end
            bus.sin_valid = 1'b0;
            bus.sin       = 1'b1;
            tick();
            if (bus.bit_cnt !== 4'(exp_cnt)) cnt_ok = 1'b0;
        end
        checks++;
        if (!cnt_ok) begin
            errors++; $display("FAIL gaps_bit_cnt got stepping on idle cycles want hold");
        end
        checks++;
        if (bus.pout_valid !== 1'b0 || bus.pout !== 16'h8001) begin
            errors++;
            $display("FAIL gaps_drain got %h valid=%b want 8001 valid=0", bus.pout, bus.pout_valid);
        end
        bus.sin = 1'b0;
    endtask

    task automatic test_overrun();
        bus.pout_ready = 1'b0;
        send_word(16'h1234, 1'b0);
        checks++;
        if (bus.pout !== 16'h1234 || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got %h valid=%b ovr=%b want 1234 1 0",
                     bus.pout, bus.pout_valid, bus.overrun);
        end
        send_word(16'hFFFF, 1'b0);
        checks++;
        if (bus.pout !== 16'h1234 || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop got %h valid=%b ovr=%b want 1234 1 1",
                     bus.pout, bus.pout_valid, bus.overrun);
        end
        bus.pout_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pout_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got valid=%b ovr=%b want 0 1", bus.pout_valid, bus.overrun);
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clr got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_back_to_back_accept();
        bus.pout_ready = 1'b0;
        send_word(16'h00FF, 1'b0);
        checks++;
        if (bus.pout !== 16'h00FF || bus.pout_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_held got %h valid=%b want 00ff 1", bus.pout, bus.pout_valid);
        end
        send_word(16'h0F0F, 1'b1);
        bus.pout_ready = 1'b0;
        checks++;
        if (bus.pout !== 16'h0F0F || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_swap got %h valid=%b ovr=%b want 0f0f 1 0",
                     bus.pout, bus.pout_valid, bus.overrun);
        end
        bus.pout_ready = 1'b1;
        tick();
    endtask

    task automatic test_clear();
        bus.pout_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin       = 1'b1;
            tick();
        end
        checks++;
        if (bus.bit_cnt !== 4'd7) begin
            errors++; $display("FAIL clr_partial got %0d want 7", bus.bit_cnt);
        end
        bus.clr = 1'b1;
        tick();
        bus.clr       = 1'b0;
        bus.sin_valid = 1'b0;
        checks++;
        if (bus.bit_cnt !== 4'd0 || bus.busy !== 1'b0 || bus.pout !== 16'h0000) begin
            errors++;
            $display("FAIL clr_state got cnt=%0d busy=%b pout=%h want 0 0 0000",
                     bus.bit_cnt, bus.busy, bus.pout);
        end
        send_word(16'hC35A, 1'b0);
        checks++;
        if (bus.pout !== 16'hC35A || bus.pout_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_word got %h valid=%b want c35a 1", bus.pout, bus.pout_valid);
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin       = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.sin_valid = 1'b0;
        checks++;
        if (bus.bit_cnt !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_state got cnt=%0d busy=%b want 0 0", bus.bit_cnt, bus.busy);
        end
        send_word(16'hC35A, 1'b0);
        checks++;
        if (bus.pout !== 16'hC35A || bus.pout_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_word got %h valid=%b want c35a 1", bus.pout, bus.pout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back_accept();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
